// File: rtl/othello_pkg.sv
// othello_pkg: shared board/task types for the endgame task feeder
package othello_pkg;

    typedef logic [63:0] board_t;

    // Widest tag the FIFO carries; the feeder's ID_W must not exceed it.
    localparam int TAG_W = 32;

    localparam int NSLOTS = 2;

    typedef struct packed {
        board_t            player;
        board_t            opponent;
        logic [TAG_W-1:0]  id;
    } task_t;

endpackage

// File: rtl/task_fifo.sv
// task_fifo: synchronous show-ahead FIFO of task_t entries
module task_fifo
    import othello_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic  iCLOCK,
    input  logic  iRESET,
    input  logic  push,
    input  task_t wdata,
    input  logic  pop,
    output task_t head,
    output logic  full,
    output logic  empty
);

    localparam int AW = $clog2(DEPTH);

    task_t         mem_q [DEPTH];
    task_t         mem_d [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign full  = cnt_q == (AW+1)'(DEPTH);
    assign empty = cnt_q == '0;
    assign head  = mem_q[rd_q];

    // A push is refused while full even if a pop happens in the same cycle.
    always_comb begin
        do_push = push && !full;
        do_pop  = pop && !empty;
        mem_d   = mem_q;
        if (do_push) mem_d[wr_q] = wdata;
        wr_d  = wr_q + AW'(do_push);
        rd_d  = rd_q + AW'(do_pop);
        cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    // Storage needs no reset; the count alone decides what is valid.
    always_ff @(posedge iCLOCK) begin
        mem_q <= mem_d;
    end

    // Pointer and occupancy registers.
    always_ff @(posedge iCLOCK) begin
        if (iRESET) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/othello_task_feeder.sv
// othello_task_feeder: keeps the pipeline's two interleaved slots fed from a task FIFO
module othello_task_feeder
    import othello_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int ID_W      = 8,
    parameter bit SLOT_SKEW = 1'b0
) (
    input  logic                iCLOCK,
    input  logic                iRESET,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [63:0]         in_player,
    input  logic [63:0]         in_opponent,
    input  logic [ID_W-1:0]     in_id,
    output logic                enable,
    output logic [63:0]         pl_player,
    output logic [63:0]         pl_opponent,
    input  logic                pl_solved,
    input  logic signed [7:0]   pl_res,
    output logic                res_valid,
    output logic [ID_W-1:0]     res_id,
    output logic signed [7:0]   res_value,
    output logic                idle
);

    task_t              fifo_in, head;
    logic               full, empty, pop;
    logic [NSLOTS-1:0]  busy_q, busy_d, free;
    logic [ID_W-1:0]    id_q [NSLOTS];
    logic [ID_W-1:0]    id_d [NSLOTS];
    board_t             ply_q [NSLOTS];
    board_t             ply_d [NSLOTS];
    board_t             opp_q [NSLOTS];
    board_t             opp_d [NSLOTS];
    logic               parity_q, parity_d, enable_q, enable_d;
    logic               res_valid_q, res_valid_d;
    logic [ID_W-1:0]    res_id_q, res_id_d;
    logic signed [7:0]  res_value_q, res_value_d;
    board_t             pl_player_q, pl_player_d, pl_opponent_q, pl_opponent_d;
    logic               solve_slot, hit, fill_slot;

    assign fifo_in = '{player: in_player, opponent: in_opponent, id: TAG_W'(in_id)};

    task_fifo #(.DEPTH(DEPTH)) u_fifo (
        .iCLOCK (iCLOCK),
        .iRESET (iRESET),
        .push   (in_valid),
        .wdata  (fifo_in),
        .pop    (pop),
        .head   (head),
        .full   (full),
        .empty  (empty)
    );

    // A solve pulse belongs to the slot currently in the pipeline's result stage;
    // a slot freed by it counts as free for a same-edge refill.
    assign solve_slot = parity_q ^ SLOT_SKEW;
    assign hit        = pl_solved && busy_q[solve_slot];
    assign free       = ~busy_q | (NSLOTS'(hit) << solve_slot);
    assign fill_slot  = !free[0];
    assign pop        = !empty && |free;

    assign in_ready    = !full;
    assign idle        = empty && ~|busy_q;
    assign enable      = enable_q;
    assign pl_player   = pl_player_q;
    assign pl_opponent = pl_opponent_q;
    assign res_valid   = res_valid_q;
    assign res_id      = res_id_q;
    assign res_value   = res_value_q;

    // Slot bookkeeping: release on solve, then refill the lowest free slot from the FIFO head.
    always_comb begin
        busy_d = busy_q;
        id_d   = id_q;
        ply_d  = ply_q;
        opp_d  = opp_q;
        if (hit) busy_d[solve_slot] = 1'b0;
        if (pop) begin
            busy_d[fill_slot] = 1'b1;
            id_d[fill_slot]   = ID_W'(head.id);
            ply_d[fill_slot]  = head.player;
            opp_d[fill_slot]  = head.opponent;
        end
    end

    // Next-cycle outputs: the board driven is that of the slot matching next cycle's parity,
    // taken from post-refill state so a freshly loaded task is visible at once.
    always_comb begin
        parity_d      = !parity_q;
        enable_d      = enable_q || (|busy_q && parity_q);
        res_valid_d   = hit;
        res_id_d      = hit ? id_q[solve_slot] : res_id_q;
        res_value_d   = hit ? pl_res : res_value_q;
        pl_player_d   = busy_d[parity_d] ? ply_d[parity_d] : '0;
        pl_opponent_d = busy_d[parity_d] ? opp_d[parity_d] : '0;
    end

    // State register; reset discards slot contents and any pending result.
    always_ff @(posedge iCLOCK) begin
        if (iRESET) begin
            busy_q        <= '0;
            id_q          <= '{default: '0};
            ply_q         <= '{default: '0};
            opp_q         <= '{default: '0};
            parity_q      <= 1'b0;
            enable_q      <= 1'b0;
            res_valid_q   <= 1'b0;
            res_id_q      <= '0;
            res_value_q   <= '0;
            pl_player_q   <= '0;
            pl_opponent_q <= '0;
        end else begin
            busy_q        <= busy_d;
            id_q          <= id_d;
            ply_q         <= ply_d;
            opp_q         <= opp_d;
            parity_q      <= parity_d;
            enable_q      <= enable_d;
            res_valid_q   <= res_valid_d;
            res_id_q      <= res_id_d;
            res_value_q   <= res_value_d;
            pl_player_q   <= pl_player_d;
            pl_opponent_q <= pl_opponent_d;
        end
    end

endmodule
